// File: rtl/lcd_camera_sequencer.sv
// lcd_camera_sequencer
// Power-up / reload sequencer for the LCD + camera component.
//  - FSM: LCD config start, SDRAM FIFO load release, staged unit enables
//    separated by a programmable delay, and a reload path driven by Nios.
//  - VSync-synchronised shadow register for the filter configuration.
//  - Active-window pixel read-enable generator.
//
// Handshake note: Config_update is a one-cycle valid qualifying Config_out.
// There is no ready; the filter pipe must take the new value in that cycle.
// Config_out itself holds its value until the next VSync falling edge.
//
// State codes (visible on State for Nios and for checkers):
//   0 RESET, 1 CFG_WAIT, 2 STAGE_WAIT, 3 STAGE_NEXT, 4 RUN, 5 RELOAD.
//   Codes 6 and 7 are unreachable and recover to RESET.

module lcd_camera_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int DELAY_W    = 20,
  parameter int CFG_W      = 32,
  parameter int H_W        = 11,
  parameter int V_W        = 10,
  parameter int H_START    = 216,
  parameter int H_ACTIVE   = 640,
  parameter int V_START    = 35,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  output logic                  Config_start,
  input  logic                  Config_done,
  output logic [NUM_STAGES-1:0] Stage_enable,
  output logic                  RD_Load,
  output logic                  WR_Load,
  input  logic [2:0]            Reload_req,
  output logic [2:0]            State,
  input  logic [DELAY_W-1:0]    Delay_limit,
  input  logic                  VSync,
  input  logic [CFG_W-1:0]      Config_in,
  output logic [CFG_W-1:0]      Config_out,
  output logic                  Config_update,
  input  logic [H_W-1:0]        H_Count,
  input  logic [V_W-1:0]        V_Count,
  input  logic                  Clock_en,
  output logic                  Read_en
);

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  localparam logic [2:0] ST_RESET      = 3'd0;
  localparam logic [2:0] ST_CFG_WAIT   = 3'd1;
  localparam logic [2:0] ST_STAGE_WAIT = 3'd2;
  localparam logic [2:0] ST_STAGE_NEXT = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;
  localparam logic [2:0] ST_RELOAD     = 3'd5;

  localparam int              IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  // Active window bounds, evaluated at counter width (unsigned, exclusive).
  localparam logic [H_W-1:0] H_LO = H_W'(H_START - 2);
  localparam logic [H_W-1:0] H_HI = H_W'(H_START - 1 + H_ACTIVE);
  localparam logic [V_W-1:0] V_LO = V_W'(V_START - 2);
  localparam logic [V_W-1:0] V_HI = V_W'(V_START - 1 + V_ACTIVE);

  // ---------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------
  logic [DELAY_W-1:0]    delay_cnt;
  logic [IDX_W-1:0]      stage_idx;
  logic [1:0]            vsync_hist;
  logic                  delay_reached;
  logic [NUM_STAGES-1:0] stage_bit;
  logic                  in_window;

  // Delay phase ends once the counter meets the threshold. Using >= means a
  // threshold lowered mid-wait ends the wait on the next cycle instead of
  // letting the counter run all the way round.
  always_comb begin
    delay_reached = (delay_cnt >= Delay_limit);
    stage_bit     = NUM_STAGES'(1) << stage_idx;
  end

  // Pixel lies strictly inside the active window (both axes).
  always_comb begin
    in_window = (H_Count > H_LO) && (H_Count < H_HI) &&
                (V_Count > V_LO) && (V_Count < V_HI);
  end

  // Sequencer FSM: config start, FIFO load release, staged enables, reload.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      State        <= ST_RESET;
      Config_start <= 1'b0;
      Stage_enable <= '0;
      RD_Load      <= 1'b1;
      WR_Load      <= 1'b1;
      delay_cnt    <= '0;
      stage_idx    <= '0;
    end else begin
      case (State)
        ST_RESET: begin
          Config_start <= 1'b1;
          State        <= ST_CFG_WAIT;
        end

        ST_CFG_WAIT: begin
          Config_start <= 1'b0;
          // Config_start must already be low so a stale Config_done from a
          // previous run cannot be taken as completion of this start pulse.
          if (Config_done && !Config_start) begin
            RD_Load   <= 1'b0;
            WR_Load   <= 1'b0;
            delay_cnt <= '0;
            stage_idx <= '0;
            State     <= ST_STAGE_WAIT;
          end
        end

        ST_STAGE_WAIT, ST_STAGE_NEXT: begin
          if (delay_reached) begin
            Stage_enable <= Stage_enable | stage_bit;
            delay_cnt    <= '0;
            if (stage_idx == LAST_IDX) begin
              State <= ST_RUN;
            end else begin
              stage_idx <= stage_idx + IDX_W'(1);
              State     <= ST_STAGE_NEXT;
            end
          end else begin
            delay_cnt <= delay_cnt + DELAY_W'(1);
          end
        end

        ST_RUN: begin
          if (Reload_req[2]) begin
            Stage_enable <= '0;
            RD_Load      <= Reload_req[0];
            WR_Load      <= Reload_req[1];
            delay_cnt    <= '0;
            State        <= ST_RELOAD;
          end
        end

        ST_RELOAD: begin
          // Count out the settle delay, then hold the counter until Nios
          // withdraws the request. Config_done is still high, so CFG_WAIT
          // exits straight away without a new config start.
          if (delay_reached) begin
            if (!Reload_req[2]) begin
              State <= ST_CFG_WAIT;
            end
          end else begin
            delay_cnt <= delay_cnt + DELAY_W'(1);
          end
        end

        default: begin
          State <= ST_RESET;
        end
      endcase
    end
  end

  // VSync shadow: reload Config_out only on a registered VSync falling edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vsync_hist    <= 2'b00;
      Config_out    <= '0;
      Config_update <= 1'b0;
    end else begin
      vsync_hist <= {vsync_hist[0], VSync};
      if (vsync_hist == 2'b10) begin
        Config_out    <= Config_in;
        Config_update <= 1'b1;
      end else begin
        Config_update <= 1'b0;
      end
    end
  end

  // Read request: only once the LCD stage is up, inside the active window,
  // and on the pixel-clock phase where Clock_en is low.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Read_en <= 1'b0;
    end else begin
      Read_en <= Stage_enable[NUM_STAGES-1] & in_window & ~Clock_en;
    end
  end

endmodule

// File: tb/tb_lcd_camera_sequencer.sv
// Bench for lcd_camera_sequencer: timeline scoreboard for the sequencer
// outputs, per-cycle queue for Read_en and a pulse queue for the config shadow.
module tb_lcd_camera_sequencer;

  localparam int NS       = 2;
  localparam int DW       = 20;
  localparam int CW       = 32;
  localparam int HW       = 11;
  localparam int VW       = 10;
  localparam int H_START  = 216;
  localparam int H_ACTIVE = 640;
  localparam int V_START  = 35;
  localparam int V_ACTIVE = 480;
  localparam int OBS_W    = NS + 6;
  localparam int EV_W     = 32 + OBS_W;

  // ---------------- clock / reset / DUT ----------------
  logic          Clock = 1'b0;
  logic          Resetn;
  logic          Config_start;
  logic          Config_done;
  logic [NS-1:0] Stage_enable;
  logic          RD_Load;
  logic          WR_Load;
  logic [2:0]    Reload_req;
  logic [2:0]    State;
  logic [DW-1:0] Delay_limit;
  logic          VSync;
  logic [CW-1:0] Config_in;
  logic [CW-1:0] Config_out;
  logic          Config_update;
  logic [HW-1:0] H_Count;
  logic [VW-1:0] V_Count;
  logic          Clock_en;
  logic          Read_en;

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  lcd_camera_sequencer #(
    .NUM_STAGES(NS), .DELAY_W(DW), .CFG_W(CW), .H_W(HW), .V_W(VW),
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Config_start(Config_start), .Config_done(Config_done),
    .Stage_enable(Stage_enable), .RD_Load(RD_Load), .WR_Load(WR_Load),
    .Reload_req(Reload_req), .State(State), .Delay_limit(Delay_limit),
    .VSync(VSync), .Config_in(Config_in), .Config_out(Config_out),
    .Config_update(Config_update), .H_Count(H_Count), .V_Count(V_Count),
    .Clock_en(Clock_en), .Read_en(Read_en)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;
  bit vs_pending = 1'b0;

  logic [EV_W-1:0]    exp_q[$];   // {cycle, State, Config_start, Stage_enable, RD, WR}
  logic [32:0]        rd_q[$];    // {cycle, Read_en}
  logic [32+CW-1:0]   cfg_q[$];   // {cycle, Config_out}

  function automatic logic [EV_W-1:0] ev(input int c, input logic [2:0] st, input logic cs,
                                         input logic [NS-1:0] se, input logic rd, input logic wr);
    return {32'(c), st, cs, se, rd, wr};
  endfunction

  // Reference for the read request: stage LCD on, strictly inside window, pixel phase low.
  function automatic logic model_read(input bit lcd_on, input int h, input int v, input logic ce);
    return lcd_on && (h > H_START - 2) && (h < H_START - 1 + H_ACTIVE) &&
           (v > V_START - 2) && (v < V_START - 1 + V_ACTIVE) && !ce;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   64'(State),         64'd0);
    check({tag, "_cfgstart"},64'(Config_start),  64'd0);
    check({tag, "_stages"},  64'(Stage_enable),  64'd0);
    check({tag, "_rdload"},  64'(RD_Load),       64'd1);
    check({tag, "_wrload"},  64'(WR_Load),       64'd1);
    check({tag, "_cfgout"},  64'(Config_out),    64'd0);
    check({tag, "_cfgupd"},  64'(Config_update), 64'd0);
    check({tag, "_readen"},  64'(Read_en),       64'd0);
  endtask

  // ---------------- monitor ----------------
  logic [OBS_W-1:0] prev_obs, cur_obs;
  logic [CW-1:0]    prev_cfg;
  logic [EV_W-1:0]  mon_e;
  logic [32:0]      mon_r;
  logic [32+CW-1:0] mon_c;

  always @(negedge Clock) begin
    cur_obs = {State, Config_start, Stage_enable, RD_Load, WR_Load};
    if (mon_on) begin
      if (cur_obs !== prev_obs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL seq_event: got change to %0h at cycle %0d, required no change", cur_obs, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if ((mon_e[EV_W-1 -: 32] != 32'(cyc)) || (mon_e[OBS_W-1:0] !== cur_obs)) begin
            n_fail++;
            $display("FAIL seq_event: got obs=%0h at cycle %0d, required obs=%0h at cycle %0d",
                     cur_obs, cyc, mon_e[OBS_W-1:0], mon_e[EV_W-1 -: 32]);
          end
        end
      end
      if (rd_q.size() > 0 && rd_q[0][32:1] == 32'(cyc)) begin
        mon_r = rd_q.pop_front();
        n_checks++;
        if (Read_en !== mon_r[0]) begin
          n_fail++;
          $display("FAIL read_en: got %b, required %b (cycle %0d, H=%0d V=%0d)",
                   Read_en, mon_r[0], cyc, H_Count, V_Count);
        end
      end
      while (cfg_q.size() > 0 && cfg_q[0][CW+31:CW] < 32'(cyc)) begin
        mon_c = cfg_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL cfg_update: got no pulse, required pulse at cycle %0d", mon_c[CW+31:CW]);
      end
      if (Config_update === 1'b1) begin
        n_checks++;
        if (cfg_q.size() == 0) begin
          n_fail++;
          $display("FAIL cfg_update: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_c = cfg_q.pop_front();
          if ((mon_c[CW+31:CW] != 32'(cyc)) || (Config_out !== mon_c[CW-1:0])) begin
            n_fail++;
            $display("FAIL cfg_update: got %0h at cycle %0d, required %0h at cycle %0d",
                     Config_out, cyc, mon_c[CW-1:0], mon_c[CW+31:CW]);
          end
        end
      end else if (Resetn && (Config_out !== prev_cfg)) begin
        n_checks++;
        n_fail++;
        $display("FAIL cfg_hold: got %0h without update, required %0h", Config_out, prev_cfg);
      end
    end
    prev_obs = cur_obs;
    prev_cfg = Config_out;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Release reset and push the expected power-up timeline.
  task automatic startup(input int L, input int done_delay, input bit stages, output int p);
    int r;
    Delay_limit = DW'(L);
    if (done_delay == 0) Config_done = 1'b1;
    @(posedge Clock);
    #1;
    r = cyc;
    Resetn = 1'b1;
    exp_q.push_back(ev(r + 1, 3'd1, 1'b1, '0, 1'b1, 1'b1));
    exp_q.push_back(ev(r + 2, 3'd1, 1'b0, '0, 1'b1, 1'b1));
    p = (done_delay + 1 > 3) ? r + done_delay + 1 : r + 3;
    exp_q.push_back(ev(p, 3'd2, 1'b0, '0, 1'b0, 1'b0));
    if (stages) begin
      for (int k = 0; k < NS; k++) begin
        exp_q.push_back(ev(p + (k + 1) * (L + 1), (k == NS - 1) ? 3'd4 : 3'd3, 1'b0,
                           NS'((1 << (k + 1)) - 1), 1'b0, 1'b0));
      end
    end
    if (done_delay > 0) begin
      wait_cyc(r + done_delay);
      Config_done = 1'b1;
    end
  endtask

  task automatic assert_reset(input string tag);
    exp_q.push_back(ev(cyc, 3'd0, 1'b0, '0, 1'b1, 1'b1));
    Resetn = 1'b0;
    #1;
    check_reset_vals(tag);
  endtask

  task automatic drive_pix(input int i, output int h, output int v, output logic ce);
    int dir_h[10] = '{215, 215, 215, 215, 215, 215, 214, 855, 215, 215};
    int dir_v[10] = '{34, 34, 34, 34, 34, 34, 34, 34, 33, 514};
    if (i < 10) begin
      h  = dir_h[i];
      v  = dir_v[i];
      ce = 1'(i % 2);
    end else begin
      case ($urandom_range(0, 7))
        0: h = 214; 1: h = 215; 2: h = 216; 3: h = 854; 4: h = 855; 5: h = 0;
        default: h = int'($urandom_range(0, 2047));
      endcase
      case ($urandom_range(0, 7))
        0: v = 33; 1: v = 34; 2: v = 35; 3: v = 513; 4: v = 514; 5: v = 0;
        default: v = int'($urandom_range(0, 1023));
      endcase
      ce = 1'($urandom_range(0, 1));
    end
    H_Count  = HW'(h);
    V_Count  = VW'(v);
    Clock_en = ce;
  endtask

  task automatic read_phase(input int n, input bit lcd_on);
    int h, v;
    logic ce;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      drive_pix(i, h, v, ce);
      rd_q.push_back({32'(cyc + 1), model_read(lcd_on, h, v, ce)});
    end
  endtask

  task automatic vs_step(input logic vs, input logic [CW-1:0] cfg);
    @(posedge Clock);
    #1;
    Config_in = cfg;
    if (vs_pending) cfg_q.push_back({32'(cyc + 1), Config_in});
    vs_pending = (VSync == 1'b1) && (vs == 1'b0);
    VSync = vs;
  endtask

  task automatic vsync_random(input int n);
    for (int i = 0; i < n; i++) begin
      vs_step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? CW'($urandom) : Config_in);
    end
    repeat (3) vs_step(1'b0, Config_in);
  endtask

  // Reload from RUN: request held for 'hold' cycles, with pixel stimulus
  // running meanwhile (stages are off, so no reads expected).
  task automatic reload(input int L, input logic rd, input logic wr, input int hold);
    int q, e, h, v;
    logic ce;
    @(posedge Clock);
    #1;
    q = cyc;
    Reload_req = {1'b1, wr, rd};
    exp_q.push_back(ev(q + 1, 3'd5, 1'b0, '0, rd, wr));
    for (int i = 1; i <= hold; i++) begin
      @(posedge Clock);
      #1;
      drive_pix(10 + i, h, v, ce);
      rd_q.push_back({32'(cyc + 1), 1'b0});
      if (i == hold) Reload_req = 3'b000;
    end
    e = (q + hold + 1 > q + 2 + L) ? q + hold + 1 : q + 2 + L;
    exp_q.push_back(ev(e,     3'd1, 1'b0, '0, rd,   wr));
    exp_q.push_back(ev(e + 1, 3'd2, 1'b0, '0, 1'b0, 1'b0));
    for (int k = 0; k < NS; k++) begin
      exp_q.push_back(ev(e + 1 + (k + 1) * (L + 1), (k == NS - 1) ? 3'd4 : 3'd3, 1'b0,
                         NS'((1 << (k + 1)) - 1), 1'b0, 1'b0));
    end
    wait_cyc(e + 1 + NS * (L + 1) + 2);
  endtask

  // ---------------- main sequence ----------------
  int p, L;

  initial begin
    Resetn = 1'b1; Config_done = 1'b0; Reload_req = 3'b000; Delay_limit = DW'(3);
    VSync = 1'b0; Config_in = '0; H_Count = '0; V_Count = '0; Clock_en = 1'b0;
    #2 Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_vals("por");
    mon_on = 1'b1;

    // Power-up with Delay_limit=3 and Config_done 10 cycles after release.
    startup(3, 10, 1'b1, p);
    wait_cyc(p + NS * 4 + 2);
    check("run_state", 64'(State), 64'd4);
    read_phase(60, 1'b1);

    // Config shadow: value must wait for the VSync falling edge.
    vs_step(1'b1, 32'hA5A5_0001);
    vs_step(1'b1, 32'hA5A5_0001);
    vs_step(1'b1, 32'hA5A5_0001);
    check("cfg_hold_a", 64'(Config_out), 64'd0);
    vs_step(1'b1, 32'h0000_0002);
    vs_step(1'b1, 32'h0000_0002);
    check("cfg_hold_b", 64'(Config_out), 64'd0);
    vs_step(1'b0, 32'h0000_0002);
    vs_step(1'b0, 32'h0000_0002);
    vs_step(1'b0, 32'h0000_0002);
    vs_step(1'b0, 32'h0000_0002);
    check("cfg_loaded", 64'(Config_out), 64'h2);
    check("cfg_upd_low", 64'(Config_update), 64'd0);
    vsync_random(80);

    // Reload with Reload_req=3'b110 held 20 cycles.
    reload(3, 1'b0, 1'b1, 20);
    check("reload_run", 64'(State), 64'd4);
    read_phase(30, 1'b1);

    // Asynchronous reset from RUN, then lowered delay mid-wait, then reset in state 3.
    assert_reset("run_rst");
    repeat (3) @(posedge Clock);
    #1;
    Config_done = 1'b0;
    startup(1000, 5, 1'b0, p);
    wait_cyc(p + 500);
    Delay_limit = DW'(100);
    exp_q.push_back(ev(p + 501, 3'd3, 1'b0, NS'(1), 1'b0, 1'b0));
    wait_cyc(p + 541);
    check("pre_rst_state3", 64'(State), 64'd3);
    assert_reset("stage3_rst");
    repeat (2) @(posedge Clock);
    #1;
    Config_done = 1'b0;
    L = int'($urandom_range(0, 7));
    startup(L, int'($urandom_range(0, 12)), 1'b1, p);
    wait_cyc(p + NS * (L + 1) + 2);
    check("restart_run", 64'(State), 64'd4);
    read_phase(40, 1'b1);
    vsync_random(60);

    // Randomised reloads with varying delay and request values.
    for (int k = 0; k < 6; k++) begin
      L = int'($urandom_range(0, 9));
      Delay_limit = DW'(L);
      reload(L, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 15)));
      read_phase(15, 1'b1);
    end

    repeat (5) @(posedge Clock);
    #1;
    check("seq_q_drained", 64'(exp_q.size()), 64'd0);
    check("rd_q_drained",  64'(rd_q.size()),  64'd0);
    check("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of sequence, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
